// File: rtl/remote_pkg.sv
// Command bytes and decoder state encoding shared by remote-driven blocks.
package remote_pkg;

  localparam logic [7:0] IR_POWER  = 8'h12;
  localparam logic [7:0] IR_PLAY   = 8'h16;
  localparam logic [7:0] IR_RETURN = 8'h17;
  localparam logic [7:0] IR_NEXT   = 8'h18;
  localparam logic [7:0] IR_PREV   = 8'h14;
  localparam logic [7:0] IR_FAST   = 8'h10;
  localparam logic [7:0] IR_SLOW   = 8'h0F;
  localparam logic [7:0] IR_NORMAL = 8'h13;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LATCH = 2'd1,
    CHECK = 2'd2
  } state_t;

endpackage

// File: rtl/ir_command_decoder_if.sv
// Frame input from IR_RECEIVE and command/status outputs toward ControlUnit.
interface ir_command_decoder_if;

  logic        iDATA_READY;
  logic [31:0] iKEYCODE;
  logic        ResetRemote;
  logic        PlayPauseRemote;
  logic        RestartRemote;
  logic        NextSongRemote;
  logic        PrevSongRemote;
  logic        Fast;
  logic        Slow;
  logic [7:0]  LastCode;
  logic [7:0]  ErrCount;

  modport master (
    output iDATA_READY, iKEYCODE,
    input  ResetRemote, PlayPauseRemote, RestartRemote, NextSongRemote,
           PrevSongRemote, Fast, Slow, LastCode, ErrCount
  );

  modport slave (
    input  iDATA_READY, iKEYCODE,
    output ResetRemote, PlayPauseRemote, RestartRemote, NextSongRemote,
           PrevSongRemote, Fast, Slow, LastCode, ErrCount
  );

endinterface

// File: rtl/ir_command_decoder_holdoff_timer.sv
// Repeat-suppression window: reloadable down-counter that parks at zero.
module holdoff_timer #(
  parameter int HOLDOFF_CYCLES = 12_500_000,
  parameter int CNT_W          = 24
) (
  input  logic CLOCK,
  input  logic Reset,
  input  logic load,
  output logic active
);

  logic [CNT_W-1:0] cnt;

  // Reload takes priority over the decrement in the same cycle.
  always_ff @(posedge CLOCK or posedge Reset) begin
    if (Reset)
      cnt <= '0;
    else if (load)
      cnt <= CNT_W'(HOLDOFF_CYCLES);
    else if (cnt != '0)
      cnt <= cnt - 1'b1;
  end

  assign active = (cnt != '0);

endmodule

// File: rtl/ir_command_decoder.sv
// Turns NEC frames into one-cycle player command pulses and a speed mode.
//   state | meaning
//   IDLE  | waiting for a rising edge of iDATA_READY
//   LATCH | settle cycle, keycode captured at the end of it
//   CHECK | checksum, repeat filter and command decode
module ir_command_decoder
  import remote_pkg::*;
#(
  parameter int HOLDOFF_CYCLES = 12_500_000,
  parameter int CNT_W          = 24
) (
  input logic CLOCK,
  input logic Reset,
  ir_command_decoder_if.slave bus
);

  state_t      state, state_nx;
  logic        rdy_q;
  logic [31:0] code_q;
  logic        rdy_edge;
  logic [7:0]  cmd;
  logic        chk_ok;
  logic        active;
  logic        accept;
  logic        rep_hit;
  logic        bad;
  logic        load;

  assign rdy_edge = bus.iDATA_READY & ~rdy_q;
  assign cmd      = code_q[23:16];
  assign chk_ok   = (code_q[31:24] == ~code_q[23:16]);
  assign load     = accept | rep_hit;

  holdoff_timer #(
    .HOLDOFF_CYCLES (HOLDOFF_CYCLES),
    .CNT_W          (CNT_W)
  ) u_holdoff (
    .CLOCK  (CLOCK),
    .Reset  (Reset),
    .load   (load),
    .active (active)
  );

  always_ff @(posedge CLOCK or posedge Reset) begin
    if (Reset)
      state <= IDLE;
    else
      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    rep_hit  = 1'b0;
    bad      = 1'b0;
    case (state)
      IDLE:  if (rdy_edge) state_nx = LATCH;
      LATCH: state_nx = CHECK;
      CHECK: begin
        state_nx = IDLE;
        if (!chk_ok)
          bad = 1'b1;
        else if (active && cmd == bus.LastCode)
          rep_hit = 1'b1;
        else
          accept = 1'b1;
      end
      default: state_nx = IDLE;
    endcase
  end

  // rdy_q resets high so a level already present at reset release is not an edge.
  always_ff @(posedge CLOCK or posedge Reset) begin
    if (Reset) begin
      rdy_q  <= 1'b1;
      code_q <= '0;
    end else begin
      rdy_q <= bus.iDATA_READY;
      if (state == LATCH)
        code_q <= bus.iKEYCODE;
    end
  end

  always_ff @(posedge CLOCK or posedge Reset) begin
    if (Reset) begin
      bus.ResetRemote     <= 1'b0;
      bus.PlayPauseRemote <= 1'b0;
      bus.RestartRemote   <= 1'b0;
      bus.NextSongRemote  <= 1'b0;
      bus.PrevSongRemote  <= 1'b0;
      bus.Fast            <= 1'b0;
      bus.Slow            <= 1'b0;
      bus.LastCode        <= 8'h00;
      bus.ErrCount        <= 8'h00;
    end else begin
      bus.ResetRemote     <= accept && cmd == IR_POWER;
      bus.PlayPauseRemote <= accept && cmd == IR_PLAY;
      bus.RestartRemote   <= accept && cmd == IR_RETURN;
      bus.NextSongRemote  <= accept && cmd == IR_NEXT;
      bus.PrevSongRemote  <= accept && cmd == IR_PREV;
      if (accept) begin
        bus.LastCode <= cmd;
        case (cmd)
          IR_FAST:   begin bus.Fast <= 1'b1; bus.Slow <= 1'b0; end
          IR_SLOW:   begin bus.Fast <= 1'b0; bus.Slow <= 1'b1; end
          IR_NORMAL: begin bus.Fast <= 1'b0; bus.Slow <= 1'b0; end
          default:   ;
        endcase
      end
      if (bad && bus.ErrCount != 8'hFF)
        bus.ErrCount <= bus.ErrCount + 8'h01;
    end
  end

endmodule

// File: tb/tb_ir_command_decoder.sv
// Directed bench for ir_command_decoder with a 100-cycle hold-off window.
module tb_ir_command_decoder;

  logic CLOCK;
  logic Reset;
  ir_command_decoder_if bus ();

  ir_command_decoder #(
    .HOLDOFF_CYCLES (100),
    .CNT_W          (8)
  ) dut (
    .CLOCK (CLOCK),
    .Reset (Reset),
    .bus   (bus.slave)
  );

  initial CLOCK = 1'b0;
  always #5 CLOCK = ~CLOCK;

  int n_checks = 0;
  int n_err    = 0;

  // Pulse order: {Reset, PlayPause, Restart, Next, Prev}
  logic [4:0] pulses;
  assign pulses = {bus.ResetRemote, bus.PlayPauseRemote, bus.RestartRemote,
                   bus.NextSongRemote, bus.PrevSongRemote};

  int pcnt [5];
  int ptotal = 0;
  int multi  = 0;
  int both   = 0;

  initial for (int i = 0; i < 5; i++) pcnt[i] = 0;

  always @(negedge CLOCK) begin
    for (int i = 0; i < 5; i++) if (pulses[i]) pcnt[i]++;
    if (pulses != 5'b0) ptotal++;
    if ($countones(pulses) > 1) multi++;
    if (bus.Fast && bus.Slow) both++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic frame(input logic [31:0] code, input int hold);
    @(negedge CLOCK);
    bus.iKEYCODE    = code;
    bus.iDATA_READY = 1'b1;
    repeat (hold) @(negedge CLOCK);
    bus.iDATA_READY = 1'b0;
    repeat (4) @(negedge CLOCK);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge CLOCK);
  endtask

  int base_tot, base_next, base_rst;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    Reset           = 1'b1;
    bus.iDATA_READY = 1'b0;
    bus.iKEYCODE    = 32'h0;
    idle(3);
    Reset = 1'b0;
    idle(2);

    chk("rst_pulses",   pulses,       5'b0);
    chk("rst_fastslow", {bus.Fast, bus.Slow}, 2'b00);
    chk("rst_lastcode", bus.LastCode, 8'h00);
    chk("rst_errcount", bus.ErrCount, 8'h00);

    // Single command with exact latency
    bus.iKEYCODE    = 32'hE916_6B86;
    bus.iDATA_READY = 1'b1;
    @(negedge CLOCK);
    chk("play_k",   pulses, 5'b00000);
    @(negedge CLOCK);
    chk("play_k1",  pulses, 5'b00000);
    @(negedge CLOCK);
    chk("play_k2",  pulses, 5'b01000);
    chk("play_last", bus.LastCode, 8'h16);
    @(negedge CLOCK);
    chk("play_k3",  pulses, 5'b00000);
    bus.iDATA_READY = 1'b0;
    idle(3);
    chk("play_count", pcnt[3], 1);

    // Bad checksum
    base_tot = ptotal;
    frame(32'h0016_6B86, 1);
    chk("bad_err1",  bus.ErrCount, 8'h01);
    chk("bad_last",  bus.LastCode, 8'h16);
    for (int i = 0; i < 299; i++) frame(32'h0016_6B86, 1);
    chk("bad_sat",   bus.ErrCount, 8'hFF);
    chk("bad_nopulse", ptotal - base_tot, 0);

    // Repeat suppression; the ignored repeats must reload the window
    idle(200);
    base_next = pcnt[1];
    frame(32'hE718_6B86, 1);
    chk("rep_first", pcnt[1] - base_next, 1);
    idle(45);
    frame(32'hE718_6B86, 1);
    chk("rep_sup1",  pcnt[1] - base_next, 1);
    idle(65);
    frame(32'hE718_6B86, 1);
    chk("rep_reload", pcnt[1] - base_next, 1);
    idle(145);
    frame(32'hE718_6B86, 1);
    chk("rep_expired", pcnt[1] - base_next, 2);

    // Speed mode
    base_tot = ptotal;
    frame(32'hEF10_6B86, 1);
    chk("spd_fast", {bus.Fast, bus.Slow}, 2'b10);
    frame(32'hF00F_6B86, 1);
    chk("spd_slow", {bus.Fast, bus.Slow}, 2'b01);
    frame(32'hEC13_6B86, 1);
    chk("spd_norm", {bus.Fast, bus.Slow}, 2'b00);
    chk("spd_last", bus.LastCode, 8'h13);
    chk("spd_nopulse", ptotal - base_tot, 0);

    // Reset during LATCH
    frame(32'hEF10_6B86, 1);
    chk("pre_rst_fast", bus.Fast, 1'b1);
    base_tot = ptotal;
    @(negedge CLOCK);
    bus.iKEYCODE    = 32'hED12_6B86;
    bus.iDATA_READY = 1'b1;
    @(negedge CLOCK);
    Reset = 1'b1;
    @(negedge CLOCK);
    bus.iDATA_READY = 1'b0;
    @(negedge CLOCK);
    Reset = 1'b0;
    idle(6);
    chk("latch_rst_nopulse", ptotal - base_tot, 0);
    chk("latch_rst_fast",    {bus.Fast, bus.Slow}, 2'b00);
    chk("latch_rst_last",    bus.LastCode, 8'h00);
    chk("latch_rst_err",     bus.ErrCount, 8'h00);

    // Level held high through reset release
    base_tot = ptotal;
    bus.iKEYCODE    = 32'hED12_6B86;
    bus.iDATA_READY = 1'b1;
    Reset = 1'b1;
    idle(2);
    Reset = 1'b0;
    idle(20);
    chk("hold_rst_nopulse", ptotal - base_tot, 0);
    chk("hold_rst_last",    bus.LastCode, 8'h00);
    bus.iDATA_READY = 1'b0;
    idle(3);

    // Long level hold produces one pulse
    base_rst = pcnt[4];
    frame(32'hED12_6B86, 1000);
    chk("level_pulse", pcnt[4] - base_rst, 1);
    chk("level_last",  bus.LastCode, 8'h12);

    chk("excl_multi", multi, 0);
    chk("excl_both",  both, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
